// File: rtl/lcd_msg_pkg.sv
// Shared types and constants for the LCD message builder: FSM states,
// ASCII label/class characters and the column layout of both display lines.
package lcd_msg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV_H,
    ST_CONV_T,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [7:0] ASCII_DIGIT0 = 8'h30;
  localparam logic [7:0] CHR_O        = 8'h4F;
  localparam logic [7:0] CHR_X        = 8'h58;
  localparam logic [7:0] CHR_NONE     = 8'h2D;
  localparam logic [7:0] CHR_INVALID  = 8'h3F;

  // Score label has only 7 characters; the 8th entry is never selected.
  localparam logic [7:0] RESULT_LBL [8] = '{"R", "e", "s", "u", "l", "t", ":", " "};
  localparam logic [7:0] SCORE_LBL  [8] = '{"S", "c", "o", "r", "e", ":", " ", " "};

  localparam logic [3:0] RESULT_LBL_LEN = 4'd8;
  localparam logic [3:0] SCORE_LBL_LEN  = 4'd7;
  localparam logic [3:0] COL_CLASS      = 4'd8;
  localparam logic [3:0] COL_DIG_H      = 4'd7;
  localparam logic [3:0] COL_DIG_T      = 4'd8;
  localparam logic [3:0] COL_DIG_O      = 4'd9;

  function automatic logic [7:0] class_char(input logic [1:0] cls);
    logic [7:0] c;
    case (cls)
      2'b01:   c = CHR_O;
      2'b10:   c = CHR_X;
      2'b00:   c = CHR_NONE;
      default: c = CHR_INVALID;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_bin2dec.sv
// Sequential binary-to-BCD divider: one subtraction of 100 (hundreds phase)
// or 10 (tens phase) per cycle; o_done flags the end of the current phase.
module lcd_bin2dec
  import lcd_msg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_value,
  input  logic       i_step_h,
  input  logic       i_step_t,
  output logic [3:0] o_hund,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_done
);

  logic [7:0] r_rem;
  logic [3:0] r_hund;
  logic [3:0] r_tens;
  logic [3:0] r_ones;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem  <= '0;
      r_hund <= '0;
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_load) begin
      r_rem  <= i_value;
      r_hund <= '0;
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_step_h) begin
      if (r_rem >= 8'd100) begin
        r_rem  <= r_rem - 8'd100;
        r_hund <= r_hund + 4'd1;
      end
    end else if (i_step_t) begin
      if (r_rem >= 8'd10) begin
        r_rem  <= r_rem - 8'd10;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_rem[3:0];
      end
    end
  end

  assign o_done = (i_step_h && (r_rem < 8'd100)) || (i_step_t && (r_rem < 8'd10));
  assign o_hund = r_hund;
  assign o_tens = r_tens;
  assign o_ones = r_ones;

endmodule

// File: rtl/lcd_msg_builder.sv
// Formats a classifier result into a 2x16 character message, written into the
// hidden bank of a double buffer and made visible only by the swap in ST_DONE.
//   state     | meaning
//   ST_IDLE   | ready for a result; capture on res_valid
//   ST_CONV_H | strip hundreds from the score
//   ST_CONV_T | strip tens; latch ones
//   ST_WRITE  | write cells 0..31 into the inactive bank
//   ST_DONE   | swap banks, bump upd_cnt
module lcd_msg_builder
  import lcd_msg_pkg::*;
#(
  parameter logic [7:0] CLR_CHAR       = 8'h20,
  parameter bit         SCORE_LABEL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic [1:0] res_class,
  input  logic [7:0] res_score,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic [7:0] upd_cnt
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_class;
  logic [4:0] r_waddr;
  logic       r_active;
  logic [7:0] r_upd_cnt;
  logic [7:0] r_rd_data;
  logic [7:0] r_bank [2][32];

  logic       w_load;
  logic       w_done;
  logic [3:0] w_hund;
  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [3:0] w_col;
  logic [7:0] w_wchar;

  assign w_load = (r_state == ST_IDLE) && res_valid;

  lcd_bin2dec u_bin2dec (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_value  (res_score),
    .i_step_h (r_state == ST_CONV_H),
    .i_step_t (r_state == ST_CONV_T),
    .o_hund   (w_hund),
    .o_tens   (w_tens),
    .o_ones   (w_ones),
    .o_done   (w_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (res_valid) w_next = ST_CONV_H;
      ST_CONV_H: if (w_done) w_next = ST_CONV_T;
      ST_CONV_T: if (w_done) w_next = ST_WRITE;
      ST_WRITE:  if (r_waddr == 5'd31) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_col   = r_waddr[3:0];
    w_wchar = CLR_CHAR;
    if (!r_waddr[4]) begin
      if (w_col < RESULT_LBL_LEN)  w_wchar = RESULT_LBL[w_col[2:0]];
      else if (w_col == COL_CLASS) w_wchar = class_char(r_class);
    end else if (SCORE_LABEL_EN) begin
      if (w_col < SCORE_LBL_LEN)   w_wchar = SCORE_LBL[w_col[2:0]];
      else if (w_col == COL_DIG_H) w_wchar = ASCII_DIGIT0 + {4'd0, w_hund};
      else if (w_col == COL_DIG_T) w_wchar = ASCII_DIGIT0 + {4'd0, w_tens};
      else if (w_col == COL_DIG_O) w_wchar = ASCII_DIGIT0 + {4'd0, w_ones};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_class   <= '0;
      r_waddr   <= '0;
      r_active  <= 1'b0;
      r_upd_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_class <= res_class;
        r_waddr <= '0;
      end
      if (r_state == ST_WRITE) r_waddr <= r_waddr + 5'd1;
      if (r_state == ST_DONE) begin
        r_active  <= ~r_active;
        r_upd_cnt <= r_upd_cnt + 8'd1;
      end
    end
  end

  // Writes only ever target the hidden bank, so readers see whole messages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 32; a++)
          r_bank[b][a] <= CLR_CHAR;
      r_rd_data <= CLR_CHAR;
    end else begin
      if (r_state == ST_WRITE) r_bank[~r_active][r_waddr] <= w_wchar;
      r_rd_data <= r_bank[r_active][rd_addr];
    end
  end

  assign res_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign upd_cnt   = r_upd_cnt;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_lcd_msg_builder.sv
// Randomized bench for lcd_msg_builder against a message-level reference model
// (whole-message images, arithmetic digit split and swap latency).
module tb_lcd_msg_builder;

  logic       clk;
  logic       rst;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_class;
  logic [7:0] res_score;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic [7:0] upd_cnt;

  int         n_vec;
  int         n_err;
  int         exp_cnt;
  logic [7:0] disp [32];

  lcd_msg_builder dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_class (res_class),
    .res_score (res_score),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .upd_cnt   (upd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_char(input int cls, input int score, input int addr);
    string l1;
    string l2;
    int    col;
    l1  = "Result: ";
    l2  = "Score: ";
    col = addr % 16;
    if (addr < 16) begin
      if (col < 8) return l1[col];
      if (col == 8) begin
        case (cls)
          0:       return 8'h2D;
          1:       return 8'h4F;
          2:       return 8'h58;
          default: return 8'h3F;
        endcase
      end
      return 8'h20;
    end
    if (col < 7)  return l2[col];
    if (col == 7) return 8'(8'h30 + score / 100);
    if (col == 8) return 8'(8'h30 + (score / 10) % 10);
    if (col == 9) return 8'(8'h30 + score % 10);
    return 8'h20;
  endfunction

  function automatic int exp_lat(input int score);
    return (score / 100 + 1) + ((score / 10) % 10 + 1) + 32 + 1;
  endfunction

  task automatic read_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      @(negedge clk);
      chk(tag, 32'(rd_data), 32'(disp[a]));
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge after the swap.
  task automatic do_pass(input int cls, input int score, input bit hold, input int ncls, input int nscore);
    logic [7:0] old [32];
    int pa;
    bit seen;
    old = disp;
    chk("ready_before", 32'(res_ready), 32'd1);
    res_valid = 1'b1;
    res_class = 2'(cls);
    res_score = 8'(score);
    @(negedge clk);
    if (hold) begin
      res_class = 2'(ncls);
      res_score = 8'(nscore);
    end else begin
      res_valid = 1'b0;
    end
    pa      = $urandom_range(0, 31);
    rd_addr = 5'(pa);
    seen    = 1'b0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(negedge clk);
      chk("poll_old_msg", 32'(rd_data), 32'(old[pa]));
      if (32'(upd_cnt) == 32'(exp_cnt)) begin
        chk("busy_in_pass", 32'(busy), 32'd1);
        chk("ready_in_pass", 32'(res_ready), 32'd0);
      end else begin
        seen = 1'b1;
        chk("swap_latency", 32'(n), 32'(exp_lat(score)));
      end
      pa      = $urandom_range(0, 31);
      rd_addr = 5'(pa);
    end
    if (!seen) chk("swap_timeout", 32'd0, 32'd1);
    exp_cnt = (exp_cnt + 1) % 256;
    chk("upd_cnt", 32'(upd_cnt), 32'(exp_cnt));
    chk("ready_after", 32'(res_ready), 32'd1);
    for (int a = 0; a < 32; a++) disp[a] = model_char(cls, score, a);
  endtask

  int cl [12];
  int sc [12];
  bit bb [12];
  int bnd [6];

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_cnt   = 0;
    rst       = 1'b0;
    res_valid = 1'b0;
    res_class = '0;
    res_score = '0;
    rd_addr   = '0;
    for (int a = 0; a < 32; a++) disp[a] = 8'h20;

    repeat (3) @(negedge clk);
    chk("rst_rd_data", 32'(rd_data), 32'h20);
    chk("rst_ready", 32'(res_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_upd_cnt", 32'(upd_cnt), 32'd0);
    read_all("rst_cells");

    do_pass(1, 0, 1'b0, 0, 0);
    read_all("msg_o_000");
    do_pass(2, 255, 1'b0, 0, 0);
    read_all("msg_x_255");

    do_pass(2, 77, 1'b1, 0, 140);
    do_pass(0, 140, 1'b0, 0, 0);
    read_all("msg_b2b");

    bnd = '{99, 100, 199, 200, 9, 10};
    for (int i = 0; i < 6; i++) begin
      do_pass($urandom_range(0, 3), bnd[i], 1'b0, 0, 0);
      read_all("msg_boundary");
    end

    for (int i = 0; i < 12; i++) begin
      cl[i] = $urandom_range(0, 3);
      sc[i] = $urandom_range(0, 255);
      bb[i] = ($urandom_range(0, 2) == 0) && (i < 11);
    end
    for (int i = 0; i < 12; i++) begin
      int nx;
      nx = (i < 11) ? i + 1 : i;
      do_pass(cl[i], sc[i], bb[i], cl[nx], sc[nx]);
      if (!bb[i]) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        read_all("msg_random");
      end
    end

    // Abort a pass in its write phase with score 123 (write starts 5 edges in).
    chk("ready_pre_abort", 32'(res_ready), 32'd1);
    res_valid = 1'b1;
    res_class = 2'd1;
    res_score = 8'd123;
    @(negedge clk);
    res_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_pre_abort", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(res_ready), 32'd1);
    chk("abort_upd_cnt", 32'(upd_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    for (int a = 0; a < 32; a++) disp[a] = 8'h20;
    repeat (40) @(negedge clk);
    chk("no_swap_after_abort", 32'(upd_cnt), 32'd0);
    chk("busy_after_abort", 32'(busy), 32'd0);
    read_all("abort_cells");
    do_pass(3, 9, 1'b0, 0, 0);
    read_all("msg_inv_009");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_msg_builder.md
LCD_MSG_BUILDER -- requirements
Module: lcd_msg_builder

Interface
REQ-001 Parameter: CLR_CHAR, default 8'h20, fill character for every unused display cell.
REQ-002 Parameter: SCORE_LABEL_EN, default 1, 1 = line 2 shows the score; 0 = line 2 is all CLR_CHAR.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 res_valid  input  1  classifier result available.
REQ-006 res_ready  output  1  block can accept a result.
REQ-007 res_class  input  2  class code: 00 none, 01 O, 10 X, 11 invalid.
REQ-008 res_score  input  8  unsigned confidence score, 0..255.
REQ-009 rd_addr  input  5  display read address: bit4 = row (0 line 1, 1 line 2), bits3:0 = column.
REQ-010 rd_data  output  8  ASCII character at rd_addr.
REQ-011 busy  output  1  a formatting pass is in progress.
REQ-012 upd_cnt  output  8  count of completed display updates, wraps 255->0.

Function
REQ-013 Two 32x8 character banks SHALL exist: reads use the active bank, writes go to the inactive bank.
REQ-014 rd_data SHALL be registered from the active bank with 1-cycle latency; reads are allowed in every state.
REQ-015 The FSM SHALL have five states: IDLE, CONV_H, CONV_T, WRITE, DONE.
REQ-016 IDLE: res_ready=1 and busy=0; when res_valid=1, capture res_class and res_score, clear the digit counters, and go to CONV_H.
REQ-017 res_ready SHALL be 0 in every state except IDLE; res_valid asserted outside IDLE is ignored, and upstream holds it.
REQ-018 CONV_H: while rem>=100, subtract 100 and increment the hundreds digit once per cycle; otherwise go to CONV_T.
REQ-019 CONV_T: while rem>=10, subtract 10 and increment the tens digit once per cycle; otherwise the ones digit = rem and go to WRITE.
REQ-020 WRITE: write one character per cycle to the inactive bank, addresses 0..31 ascending; after address 31, go to DONE.
REQ-021 Line 1 layout: "Result: " (cols 0-7), class char at col 8 ('O' 8'h4F, 'X' 8'h58, '-' 8'h2D for none, '?' 8'h3F for invalid), cols 9-15 CLR_CHAR.
REQ-022 Line 2 layout: "Score: " (cols 0-6), three ASCII digits at cols 7-9 with leading zeros kept (8'h30 + digit), cols 10-15 CLR_CHAR; when SCORE_LABEL_EN=0, all cols are CLR_CHAR.
REQ-023 DONE: toggle the active bank, increment upd_cnt modulo 256, and return to IDLE after one cycle.
REQ-024 Timing: the bank swap SHALL occur exactly (H+1)+(T+1)+32+1 cycles after the accept edge, where H = hundreds digit and T = tens digit (35 cycles for score 0, 42 for score 255).
REQ-025 A new result SHALL be accepted in the first IDLE cycle after DONE, giving back-to-back updates with no extra gap.
REQ-026 The active bank SHALL never change except at DONE, so the downstream LCD driver never sees a partial message.

Reset
REQ-027 On rst=0: state IDLE, active bank 0, both banks filled with CLR_CHAR, rd_data=CLR_CHAR, upd_cnt=0, res_ready=1 (follows IDLE), busy=0, and digit counters and captured registers cleared.
REQ-028 Reset asserted mid-pass SHALL abort the pass immediately; no swap occurs and upd_cnt is not incremented.

Structure
REQ-029 Package lcd_msg_pkg SHALL hold the FSM state typedef, the ASCII constants (labels, class chars, digit base 8'h30), and the layout column offsets.
REQ-030 Sub-module lcd_bin2dec SHALL implement the CONV_H/CONV_T sequential divider, outputting three BCD digits plus a done flag.

Verification
REQ-031 Reset then read addr 0..31 -> all 8'h20, upd_cnt=0, res_ready=1.
REQ-032 class=01, score=0 -> swap 35 cycles after accept; line 1 reads "Result: O", line 2 reads "Score: 000"; upd_cnt=1.
REQ-033 class=10, score=255 -> swap after 42 cycles; col 8 = 8'h58; cols 7-9 = "255".
REQ-034 res_valid held high throughout a pass with new data -> ignored until IDLE, then accepted on the next cycle; the display shows the second result after the second swap.
REQ-035 Poll rd_addr continuously during WRITE -> rd_data always matches the previous complete message, never a mix of old and new.
REQ-036 rst pulsed during WRITE -> all cells 8'h20, upd_cnt=0, active bank 0; a following class=11, score=9 gives '?' and "009".
